mat_row_server: RTL and testbench



---
 rtl/mat_row_server.sv | 107 ++++++++++
 tb/tb_mat_row_server.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mat_row_server.sv
// Matrix-row responder for the triangular inverse engine: element-wise matrix load,
// fixed-latency tagged row responses with optional lower-triangular masking, and result column capture.
module mat_row_server #(
   parameter int unsigned SIZE    = 16,
   parameter int unsigned LATENCY = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       ld_valid_i,
   input  logic [$clog2(SIZE)-1:0]    ld_row_i,
   input  logic [$clog2(SIZE)-1:0]    ld_col_i,
   input  logic [127:0]               ld_data_i,
   input  logic                       req_valid_i,
   input  logic [$clog2(SIZE)-1:0]    req_addr_i,
   output logic [SIZE*128-1:0]        row_o,
   output logic                       row_valid_o,
   output logic [$clog2(SIZE)-1:0]    row_addr_o,
   input  logic                       mask_upper_i,
   input  logic                       res_valid_i,
   input  logic [SIZE*128-1:0]        res_col_i,
   input  logic [$clog2(SIZE)-1:0]    res_rd_col_i,
   output logic [SIZE*128-1:0]        res_rd_data_o,
   output logic                       res_done_o,
   input  logic                       flush_i,
   output logic                       busy_o
);

   localparam int unsigned AW = $clog2(SIZE);
   localparam int unsigned EW = 128;

   logic [SIZE*EW-1:0] mat_q  [SIZE];
   logic [SIZE*EW-1:0] res_q  [SIZE];
   logic [SIZE*EW-1:0] data_q [LATENCY];
   logic [AW-1:0]      addr_q [LATENCY];
   logic [LATENCY-1:0] vld_q;
   logic [AW-1:0]      ptr_q, ptr_d;
   logic               done_q, done_d;
   logic [SIZE*EW-1:0] launch_row;

   // Row read happens before the same-edge load write, so a colliding load is not visible.
   always_comb begin
      launch_row = mat_q[req_addr_i];
      if (mask_upper_i) begin
         for (int unsigned c = 0; c < SIZE; c++) begin
            if (AW'(c) > req_addr_i) launch_row[c*EW +: EW] = '0;
         end
      end
   end

   always_comb begin
      ptr_d  = ptr_q;
      done_d = done_q;
      if (flush_i) begin
         ptr_d  = '0;
         done_d = 1'b0;
      end else if (res_valid_i) begin
         if (ptr_q == AW'(SIZE - 1)) begin
            ptr_d  = '0;
            done_d = 1'b1;
         end else begin
            ptr_d = ptr_q + AW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < SIZE; i++) begin
            mat_q[i] <= '0;
            res_q[i] <= '0;
         end
         for (int unsigned i = 0; i < LATENCY; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
         vld_q  <= '0;
         ptr_q  <= '0;
         done_q <= 1'b0;
      end else begin
         if (ld_valid_i) mat_q[ld_row_i][int'(ld_col_i)*EW +: EW] <= ld_data_i;
         if (!flush_i && res_valid_i) res_q[ptr_q] <= res_col_i;
         ptr_q  <= ptr_d;
         done_q <= done_d;

         data_q[0] <= launch_row;
         addr_q[0] <= req_addr_i;
         for (int unsigned i = 1; i < LATENCY; i++) begin
            data_q[i] <= data_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
         if (flush_i) begin
            vld_q <= '0;
         end else begin
            vld_q[0] <= req_valid_i;
            for (int unsigned i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
         end
      end
   end

   assign row_o         = data_q[LATENCY-1];
   assign row_addr_o    = addr_q[LATENCY-1];
   assign row_valid_o   = vld_q[LATENCY-1];
   assign busy_o        = |vld_q;
   assign res_done_o    = done_q;
   assign res_rd_data_o = res_q[res_rd_col_i];

endmodule

// File: tb/tb_mat_row_server.sv
// Directed bench for mat_row_server: a LATENCY=2 and a LATENCY=1 instance share all inputs.
module tb_mat_row_server;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ld_valid, req_valid, mask, res_valid, flush;
   logic [3:0]    ld_row, ld_col, req_addr, res_rd_col;
   logic [127:0]  ld_data;
   logic [2047:0] res_col;

   logic [2047:0] row0, row1, rrd0, rrd1;
   logic          rv0, rv1, done0, done1, busy0, busy1;
   logic [3:0]    ra0, ra1;

   int unsigned checks = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   mat_row_server #(.SIZE(16), .LATENCY(2)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_row_i(ld_row), .ld_col_i(ld_col),
      .ld_data_i(ld_data), .req_valid_i(req_valid), .req_addr_i(req_addr), .row_o(row0),
      .row_valid_o(rv0), .row_addr_o(ra0), .mask_upper_i(mask), .res_valid_i(res_valid),
      .res_col_i(res_col), .res_rd_col_i(res_rd_col), .res_rd_data_o(rrd0), .res_done_o(done0),
      .flush_i(flush), .busy_o(busy0));

   mat_row_server #(.SIZE(16), .LATENCY(1)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .ld_valid_i(ld_valid), .ld_row_i(ld_row), .ld_col_i(ld_col),
      .ld_data_i(ld_data), .req_valid_i(req_valid), .req_addr_i(req_addr), .row_o(row1),
      .row_valid_o(rv1), .row_addr_o(ra1), .mask_upper_i(mask), .res_valid_i(res_valid),
      .res_col_i(res_col), .res_rd_col_i(res_rd_col), .res_rd_data_o(rrd1), .res_done_o(done1),
      .flush_i(flush), .busy_o(busy1));

   typedef struct {
      logic [3:0]   addr;
      logic         mask;
      logic [3:0]   col;
      logic [127:0] exp_elem;
      int unsigned  exp_nz;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] elem(input logic [2047:0] r, input int unsigned c);
      return r[c*128 +: 128];
   endfunction

   function automatic int unsigned nz(input logic [2047:0] r);
      int unsigned n = 0;
      for (int unsigned c = 0; c < 16; c++) if (r[c*128 +: 128] != '0) n++;
      return n;
   endfunction

   task automatic res_pulse(input logic [127:0] v);
      @(negedge clk);
      res_valid = 1'b1;
      res_col   = {16{v}};
      @(negedge clk);
      res_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{4'd5,  1'b0, 4'd3,  {64'd3, 64'd5},   16};
      vecs[1] = '{4'd3,  1'b1, 4'd2,  {64'd2, 64'd3},   4};
      vecs[2] = '{4'd3,  1'b1, 4'd4,  128'h0,           4};
      vecs[3] = '{4'd3,  1'b0, 4'd15, {64'd15, 64'd3},  16};
      vecs[4] = '{4'd0,  1'b1, 4'd0,  128'h0,           0};
      vecs[5] = '{4'd15, 1'b1, 4'd15, {64'd15, 64'd15}, 16};
      vecs[6] = '{4'd0,  1'b0, 4'd7,  {64'd7, 64'd0},   15};

      rst_n = 1'b0; ld_valid = 0; req_valid = 0; mask = 0; res_valid = 0; flush = 0;
      ld_row = 0; ld_col = 0; req_addr = 0; res_rd_col = 0; ld_data = '0; res_col = '0;
      #22 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_row_valid", 128'(rv0), 128'd0);
      chk("rst_busy", 128'(busy0), 128'd0);
      chk("rst_done", 128'(done0), 128'd0);
      chk("rst_row_zero", 128'(row0 == '0), 128'd1);
      chk("rst_res_rd_zero", 128'(rrd0 == '0), 128'd1);

      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            ld_valid = 1'b1; ld_row = 4'(r); ld_col = 4'(c); ld_data = {64'(c), 64'(r)};
            @(negedge clk);
         end
      end
      ld_valid = 1'b0;

      for (int i = 0; i < 7; i++) begin
         req_valid = 1'b1; req_addr = vecs[i].addr; mask = vecs[i].mask;
         @(negedge clk);
         req_valid = 1'b0; mask = 1'b0;
         chk($sformatf("v%0d_lat1_valid", i), 128'(rv1), 128'd1);
         chk($sformatf("v%0d_lat1_tag", i), 128'(ra1), 128'(vecs[i].addr));
         chk($sformatf("v%0d_lat1_elem", i), elem(row1, vecs[i].col), vecs[i].exp_elem);
         chk($sformatf("v%0d_lat2_early", i), 128'(rv0), 128'd0);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), 128'(rv0), 128'd1);
         chk($sformatf("v%0d_tag", i), 128'(ra0), 128'(vecs[i].addr));
         chk($sformatf("v%0d_elem", i), elem(row0, vecs[i].col), vecs[i].exp_elem);
         chk($sformatf("v%0d_nonzero", i), 128'(nz(row0)), 128'(vecs[i].exp_nz));
         chk($sformatf("v%0d_lat1_pulse", i), 128'(rv1), 128'd0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", i), 128'(rv0), 128'd0);
      end

      begin
         int unsigned nvalid = 0;
         for (int t = 0; t < 21; t++) begin
            chk($sformatf("b2b_valid_t%0d", t), 128'(rv0), 128'(t >= 2 && t <= 17));
            if (t >= 2 && t <= 17) chk($sformatf("b2b_tag_t%0d", t), 128'(ra0), 128'(t - 2));
            chk($sformatf("b2b_busy_t%0d", t), 128'(busy0), 128'(t >= 1 && t <= 17));
            chk($sformatf("b2b_lat1_valid_t%0d", t), 128'(rv1), 128'(t >= 1 && t <= 16));
            if (t >= 1 && t <= 16) chk($sformatf("b2b_lat1_tag_t%0d", t), 128'(ra1), 128'(t - 1));
            if (rv0) nvalid++;
            req_valid = (t < 16);
            req_addr  = 4'(t);
            @(negedge clk);
         end
         chk("b2b_count", 128'(nvalid), 128'd16);
      end

      ld_valid = 1'b1; ld_row = 4'd7; ld_col = 4'd2; ld_data = 128'hCAFE_F00D_0000_0001_1234_5678_9ABC_DEF0;
      req_valid = 1'b1; req_addr = 4'd7;
      @(negedge clk);
      ld_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rbw_old_tag", 128'(ra0), 128'd7);
      chk("rbw_old", elem(row0, 2), {64'd2, 64'd7});
      @(negedge clk);
      chk("rbw_new_valid", 128'(rv0), 128'd1);
      chk("rbw_new", elem(row0, 2), 128'hCAFE_F00D_0000_0001_1234_5678_9ABC_DEF0);

      for (int k = 0; k < 16; k++) begin
         res_pulse(128'(k));
         if (k == 14) chk("res_done_15", 128'(done0), 128'd0);
      end
      chk("res_done_16", 128'(done0), 128'd1);
      res_rd_col = 4'd9; #1;
      chk("res_rd9", elem(rrd0, 0), 128'd9);
      chk("res_rd9_full", 128'(rrd0 == {16{128'd9}}), 128'd1);
      res_pulse(128'd100);
      res_rd_col = 4'd0; #1;
      chk("res_wrap_col0", elem(rrd0, 15), 128'd100);
      chk("res_done_sticky", 128'(done0), 128'd1);
      res_rd_col = 4'd1; #1;
      chk("res_col1_kept", elem(rrd0, 0), 128'd1);

      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush_done_clr", 128'(done0), 128'd0);
      for (int k = 0; k < 4; k++) res_pulse(128'(200 + k));
      @(negedge clk); req_valid = 1'b1; req_addr = 4'd1;
      @(negedge clk); req_addr = 4'd2;
      @(negedge clk); req_addr = 4'd3; flush = 1'b1; res_valid = 1'b1; res_col = {16{128'd999}};
      @(negedge clk); req_valid = 1'b0; flush = 1'b0; res_valid = 1'b0;
      for (int t = 0; t < 4; t++) begin
         chk($sformatf("flush_no_resp_t%0d", t), 128'(rv0 | rv1), 128'd0);
         chk($sformatf("flush_busy_t%0d", t), 128'(busy0 | busy1), 128'd0);
         @(negedge clk);
      end
      chk("flush_done", 128'(done0), 128'd0);
      res_rd_col = 4'd4; #1;
      chk("flush_res_ignored", elem(rrd0, 0), 128'd4);
      res_pulse(128'd300);
      res_rd_col = 4'd0; #1;
      chk("flush_ptr_col0", elem(rrd0, 0), 128'd300);
      res_rd_col = 4'd1; #1;
      chk("flush_col1_kept", elem(rrd0, 0), 128'd201);

      @(negedge clk); req_valid = 1'b1; req_addr = 4'd9;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_valid", 128'(rv0), 128'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_row_valid", 128'(rv0 | rv1), 128'd0);
      chk("arst_row_zero", 128'(row0 == '0), 128'd1);
      chk("arst_tag", 128'(ra0), 128'd0);
      chk("arst_busy", 128'(busy0 | busy1), 128'd0);
      chk("arst_res_rd", 128'(rrd0 == '0), 128'd1);
      chk("arst_done", 128'(done0 | done1), 128'd0);
      #10 rst_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
